// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Brief    : Shared constants, channel output type and counter-width helper
//            for the debounced input bank.
// Revision : 1.0
// ============================================================================
package io_pkg;

    localparam int IO_MAX_CH       = 16;
    localparam int IO_STATUS_WIDTH = 32;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } io_ch_out_t;

    // Smallest width able to hold cycles-1 (at least one bit).
    function automatic int io_cnt_width(input int cycles);
        int w;
        w = 1;
        for (int i = 1; i <= 16; i++) begin
            if ((1 << i) < cycles) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Brief    : One input channel: 2-flop synchronizer, stability counter,
//            debounced level and one-cycle edge pulses.
// Revision : 1.0
// ============================================================================
module debounce_channel
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_i,
    output io_ch_out_t out_o
);

    localparam int              CNT_W   = io_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             mismatch;
    logic             expire;

    // Counter never exceeds CNT_MAX: it either resets or toggles level there.
    always_comb begin
        mismatch = sync_q[1] ^ level_q;
        expire   = mismatch && (cnt_q == CNT_MAX);
        cnt_d    = '0;
        if (mismatch && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
        level_d  = level_q ^ expire;
        rise_d   = expire & ~level_q;
        fall_d   = expire &  level_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out_o.level = level_q;
    assign out_o.rise  = rise_q;
    assign out_o.fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/io_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module   : io_debounce_bank
// Brief    : Bank of debounced inputs with sticky edge flags, status word and
//            optional interrupt (enabled by macro IO_DEBOUNCE_IRQ_EN).
// Revision : 1.0
// ============================================================================
module io_debounce_bank
    import io_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          raw_in,
    input  logic                       clear_valid,
    input  logic [NUM_CH-1:0]          clear_mask,
    input  logic [NUM_CH-1:0]          irq_mask,
    output logic [NUM_CH-1:0]          level,
    output logic [NUM_CH-1:0]          rise_pulse,
    output logic [NUM_CH-1:0]          fall_pulse,
    output logic [NUM_CH-1:0]          sticky,
    output logic [IO_STATUS_WIDTH-1:0] status_word,
    output logic                       irq
);

    io_ch_out_t [NUM_CH-1:0] ch_out;
    logic       [NUM_CH-1:0] sticky_q;
    logic       [NUM_CH-1:0] sticky_d;
    logic       [NUM_CH-1:0] clr_eff;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw_i (raw_in[g]),
            .out_o (ch_out[g])
        );
        assign level[g]      = ch_out[g].level;
        assign rise_pulse[g] = ch_out[g].rise;
        assign fall_pulse[g] = ch_out[g].fall;
    end

    // Setting from a visible pulse takes priority over a same-cycle clear.
    always_comb begin
        clr_eff  = clear_valid ? clear_mask : '0;
        sticky_d = (sticky_q & ~clr_eff) | rise_pulse | fall_pulse;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky      = sticky_q;
    assign status_word = IO_STATUS_WIDTH'({sticky_q, level});

`ifdef IO_DEBOUNCE_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(sticky_q & irq_mask);
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_mask;

    assign unused_irq_mask = ^irq_mask;
    assign irq             = 1'b0;
`endif

endmodule
`default_nettype wire
